rx_substate_supervisor: RTL and testbench
=========================================

RX_SUBSTATE_SUPERVISOR -- requirements
Module: rx_substate_supervisor

Interface
REQ-001 SHALL have parameters: MAXLANES, 16, lane count; CYC_PER_MS, 250000, clk cycles per 1 ms; MAX_RETRY, 2, RcvrLock re-arms before failing.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low.
REQ-003 SHALL have ports: substate  in  5  current LTSSM substate code (0..18); activeLanes  in  MAXLANES  mask of configured lanes.
REQ-004 SHALL have ports: laneOsDone  in  MAXLANES  per-lane OS checker satisfied; rxIdleExit  in  1  electrical-idle exit seen; exitToIdle  in  1  RcvrCfg-to-Idle request; trainToGen  in  3  target generation.
REQ-005 SHALL have ports: finish  out  1  one-cycle done pulse; exitTo  out  5  next substate; failed  out  1  qualifies finish as failure; busy  out  1  evaluation in progress.
REQ-006 SHALL have ports: resetOsCheckers  out  MAXLANES  per-lane active-low checker reset; disableDescrambler  out  1  descrambler bypass.

Function
REQ-007 SHALL implement states IDLE, ARM, COUNT, DONE; every output SHALL be registered.
REQ-008 IDLE: substate != lastDone (reset value 5'h1F) and substate <= 18 -> ARM; codes 19..31 SHALL never arm.
REQ-009 ARM (one cycle): clear internal timer, load timeout and rule from table, drive resetOsCheckers = activeLanes; busy=1; -> COUNT.
REQ-010 Timeout table (ms): detectQuiet 12; detectActive 0; pollingActive, configurationComplete 24; pollingConfiguration, recoveryRcvrLock, recoveryRcvrCfg 48; configurationLinkWidthStart/Accept, LanenumAccept, phase0..3 24; configurationLanenumWait, configurationIdle 2; recoverySpeed 1; L0, recoveryIdle 2.
REQ-011 Timer SHALL count clk cycles in COUNT; timeout asserts when count == ms*CYC_PER_MS; width SHALL hold 48*CYC_PER_MS without wrap; timer SHALL saturate at timeout.
REQ-012 laneOk SHALL be (laneOsDone & activeLanes) == activeLanes and activeLanes != 0; any lane mask SHALL be accepted, not only x1/2/4/8/16.
REQ-013 Success rule: detectQuiet -> rxIdleExit or timeout; detectActive -> first COUNT cycle; recoverySpeed -> laneOk and timeout; all others -> laneOk.
REQ-014 laneOk and timeout in the same cycle SHALL be success.
REQ-015 Timeout without success SHALL be failure, except recoveryRcvrLock with retryCnt < MAX_RETRY: retryCnt++, -> ARM, no finish.
REQ-016 Success exitTo: exitToIdle -> 18; else phase3 -> 11; recoveryIdle -> 10; recoverySpeed with trainToGen != 3 -> 11; otherwise substate+1.
REQ-017 Failure exitTo SHALL be 0 (detectQuiet), failed=1.
REQ-018 DONE: finish=1 for exactly one cycle, lastDone <= substate, retryCnt <= 0, resetOsCheckers <= 0, busy <= 0; -> IDLE.
REQ-019 Substate change while in ARM or COUNT SHALL abort: no finish, retryCnt <= 0, -> ARM for the new code on the next cycle.
REQ-020 Latency: change seen in IDLE at cycle N -> ARM N+1 -> COUNT N+2; success detected at cycle M -> finish/exitTo valid at M+1.
REQ-021 exitTo and failed SHALL hold their values until the next DONE.
REQ-022 disableDescrambler SHALL be 0 while substate is 10 (L0) or 18, and 1 otherwise, updated each cycle.
REQ-023 resetOsCheckers SHALL be all 0 in IDLE and DONE.

Reset
REQ-024 reset low SHALL force, asynchronously: state IDLE, finish 0, failed 0, busy 0, exitTo 0, resetOsCheckers 0, disableDescrambler 1, lastDone 5'h1F, retryCnt 0, timer 0.
REQ-025 Reset during COUNT SHALL discard the evaluation; after release, the current substate SHALL re-arm as new.

Verification
REQ-026 CYC_PER_MS=10, substate=2, activeLanes=0x000F, laneOsDone=0x000F at COUNT cycle 5 -> finish at cycle 6, exitTo=3, failed=0.
REQ-027 substate=11, activeLanes=0x0003, laneOsDone=0x0001, MAX_RETRY=2 -> two silent re-arms after 480 cycles each, then finish, failed=1, exitTo=0.
REQ-028 substate=13, trainToGen=2, laneOk from COUNT cycle 1 -> finish only after the 10-cycle timeout, exitTo=11.
REQ-029 substate=12 with exitToIdle=1 and laneOk -> exitTo=18; substate 4 changed to 5 mid-COUNT -> no finish, ARM for 5.
REQ-030 activeLanes=0x0005 (non-power-of-two), laneOsDone=0x0007 -> success; reset pulse mid-COUNT -> outputs per REQ-024, same substate re-armed.

Source files
------------

// File: rtl/rx_substate_supervisor.sv
// rtl/rx_substate_supervisor.sv - per-substate receive supervisor for the LTSSM
// Arms lane OS checkers, times the substate, and reports success, failure or next substate.
module rx_substate_supervisor #(
  parameter int MAXLANES   = 16,
  parameter int CYC_PER_MS = 250000,
  parameter int MAX_RETRY  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          substate,
  input  logic [MAXLANES-1:0] activeLanes,
  input  logic [MAXLANES-1:0] laneOsDone,
  input  logic                rxIdleExit,
  input  logic                exitToIdle,
  input  logic [2:0]          trainToGen,
  output logic                finish,
  output logic [4:0]          exitTo,
  output logic                failed,
  output logic                busy,
  output logic [MAXLANES-1:0] resetOsCheckers,
  output logic                disableDescrambler
);

  localparam int TMAX = 48 * CYC_PER_MS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [4:0] SUB_DETECT_QUIET  = 5'd0;
  localparam logic [4:0] SUB_L0            = 5'd10;
  localparam logic [4:0] SUB_RCVR_LOCK     = 5'd11;
  localparam logic [4:0] SUB_SPEED         = 5'd13;
  localparam logic [4:0] SUB_PHASE3        = 5'd17;
  localparam logic [4:0] SUB_RECOVERY_IDLE = 5'd18;
  localparam logic [4:0] SUB_MAX           = 5'd18;
  localparam logic [4:0] LAST_NONE         = 5'h1F;

  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;
  typedef enum logic [1:0] {RULE_QUIET, RULE_ACTIVE, RULE_SPEED, RULE_LANES} rule_t;

  state_t           state;
  rule_t            rule;
  logic [4:0]       curSub;
  logic [4:0]       lastDone;
  logic [TW-1:0]    timer;
  logic [TW-1:0]    limit;
  logic [RW-1:0]    retryCnt;

  logic             laneOk;
  logic             timeout;
  logic             success;
  logic             canRetry;
  logic [4:0]       successExit;

  function automatic int msOf(input logic [4:0] s);
    case (s)
      5'd0:                                msOf = 12;
      5'd1:                                msOf = 0;
      5'd2, 5'd4, 5'd5, 5'd7, 5'd8,
      5'd14, 5'd15, 5'd16, 5'd17:          msOf = 24;
      5'd3, 5'd11, 5'd12:                  msOf = 48;
      5'd6, 5'd9, 5'd10, 5'd18:            msOf = 2;
      5'd13:                               msOf = 1;
      default:                             msOf = 0;
    endcase
  endfunction

  function automatic logic [TW-1:0] limitOf(input logic [4:0] s);
    limitOf = TW'(msOf(s) * CYC_PER_MS);
  endfunction

  function automatic rule_t ruleOf(input logic [4:0] s);
    case (s)
      5'd0:    ruleOf = RULE_QUIET;
      5'd1:    ruleOf = RULE_ACTIVE;
      5'd13:   ruleOf = RULE_SPEED;
      default: ruleOf = RULE_LANES;
    endcase
  endfunction

  always_comb begin
    laneOk   = ((laneOsDone & activeLanes) == activeLanes) && (activeLanes != '0);
    timeout  = (timer == limit);
    canRetry = (curSub == SUB_RCVR_LOCK) && (retryCnt < RW'(MAX_RETRY));
    case (rule)
      RULE_QUIET:  success = rxIdleExit || timeout;
      RULE_ACTIVE: success = 1'b1;
      RULE_SPEED:  success = laneOk && timeout;
      default:     success = laneOk;
    endcase
    if (exitToIdle)
      successExit = SUB_RECOVERY_IDLE;
    else if (curSub == SUB_PHASE3)
      successExit = SUB_RCVR_LOCK;
    else if (curSub == SUB_RECOVERY_IDLE)
      successExit = SUB_L0;
    else if ((curSub == SUB_SPEED) && (trainToGen != 3'd3))
      successExit = SUB_RCVR_LOCK;
    else
      successExit = curSub + 5'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      rule               <= RULE_LANES;
      curSub             <= '0;
      lastDone           <= LAST_NONE;
      timer              <= '0;
      limit              <= '0;
      retryCnt           <= '0;
      finish             <= 1'b0;
      exitTo             <= '0;
      failed             <= 1'b0;
      busy               <= 1'b0;
      resetOsCheckers    <= '0;
      disableDescrambler <= 1'b1;
    end else begin
      disableDescrambler <= !((substate == SUB_L0) || (substate == SUB_RECOVERY_IDLE));

      // A new code mid-evaluation restarts from ARM; out-of-range codes just drop back to IDLE.
      if (((state == ARM) || (state == COUNT)) && (substate != curSub)) begin
        retryCnt <= '0;
        timer    <= '0;
        if (substate <= SUB_MAX) begin
          curSub <= substate;
          state  <= ARM;
        end else begin
          busy            <= 1'b0;
          resetOsCheckers <= '0;
          state           <= IDLE;
        end
      end else begin
        case (state)
          IDLE: begin
            if ((substate != lastDone) && (substate <= SUB_MAX)) begin
              curSub <= substate;
              busy   <= 1'b1;
              state  <= ARM;
            end
          end
          ARM: begin
            timer           <= '0;
            limit           <= limitOf(curSub);
            rule            <= ruleOf(curSub);
            resetOsCheckers <= activeLanes;
            busy            <= 1'b1;
            state           <= COUNT;
          end
          COUNT: begin
            if (success) begin
              finish          <= 1'b1;
              exitTo          <= successExit;
              failed          <= 1'b0;
              resetOsCheckers <= '0;
              state           <= DONE;
            end else if (timeout) begin
              if (canRetry) begin
                retryCnt <= retryCnt + RW'(1);
                state    <= ARM;
              end else begin
                finish          <= 1'b1;
                exitTo          <= SUB_DETECT_QUIET;
                failed          <= 1'b1;
                resetOsCheckers <= '0;
                state           <= DONE;
              end
            end else begin
              timer <= timer + TW'(1);
            end
          end
          DONE: begin
            finish          <= 1'b0;
            lastDone        <= substate;
            retryCnt        <= '0;
            resetOsCheckers <= '0;
            busy            <= 1'b0;
            state           <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_substate_supervisor.sv
// tb/tb_rx_substate_supervisor.sv - scoreboard bench for rx_substate_supervisor
module tb_rx_substate_supervisor;

  logic        clk;
  logic        reset;
  logic [4:0]  substate;
  logic [15:0] activeLanes;
  logic [15:0] laneOsDone;
  logic        rxIdleExit;
  logic        exitToIdle;
  logic [2:0]  trainToGen;
  logic        finish;
  logic [4:0]  exitTo;
  logic        failed;
  logic        busy;
  logic [15:0] resetOsCheckers;
  logic        disableDescrambler;

  rx_substate_supervisor #(
    .MAXLANES(16), .CYC_PER_MS(10), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .reset(reset), .substate(substate), .activeLanes(activeLanes),
    .laneOsDone(laneOsDone), .rxIdleExit(rxIdleExit), .exitToIdle(exitToIdle),
    .trainToGen(trainToGen), .finish(finish), .exitTo(exitTo), .failed(failed),
    .busy(busy), .resetOsCheckers(resetOsCheckers), .disableDescrambler(disableDescrambler)
  );

  typedef struct {
    int         cycle;
    logic [4:0] exitTo;
    logic       failed;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   nCmp = 0;
  int   nBad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectFinish(input int lat, input logic [4:0] ex, input logic fl);
    exp_t e;
    e.cycle  = cyc + lat;
    e.exitTo = ex;
    e.failed = fl;
    sb.push_back(e);
  endtask

  task automatic waitDone(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      step(1);
      n++;
    end
    if (sb.size() != 0) begin
      check("finish_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  // Monitor: every finish pulse must match the oldest expected outcome.
  always @(negedge clk) begin
    if (reset && finish) begin
      if (sb.size() == 0) begin
        check("unexpected_finish", {27'd0, exitTo}, 32'h1F);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("finish_cycle", 32'(cyc), 32'(e.cycle));
        check("exitTo", {27'd0, exitTo}, {27'd0, e.exitTo});
        check("failed", {31'd0, failed}, {31'd0, e.failed});
        check("rstchk_done", {16'd0, resetOsCheckers}, 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; substate = 5'd31; activeLanes = '0; laneOsDone = '0;
    rxIdleExit = 1'b0; exitToIdle = 1'b0; trainToGen = 3'd3;
    step(2);
    check("rst_finish", {31'd0, finish}, 0);
    check("rst_failed", {31'd0, failed}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_exitTo", {27'd0, exitTo}, 0);
    check("rst_rstchk", {16'd0, resetOsCheckers}, 0);
    check("rst_dd", {31'd0, disableDescrambler}, 1);
    reset = 1'b1;
    step(4);
    check("no_arm_31", {31'd0, busy}, 0);
    substate = 5'd19;
    step(4);
    check("no_arm_19", {31'd0, busy}, 0);
    check("dd_19", {31'd0, disableDescrambler}, 1);

    // pollingActive, lanes satisfied at COUNT cycle 5
    activeLanes = 16'h000F; laneOsDone = '0; substate = 5'd2;
    expectFinish(7, 5'd3, 1'b0);
    step(3);
    check("busy_count", {31'd0, busy}, 1);
    check("rstchk_count", {16'd0, resetOsCheckers}, 32'h000F);
    step(3);
    laneOsDone = 16'h000F;
    waitDone(50);
    step(2);
    check("exit_hold", {27'd0, exitTo}, 3);
    check("busy_idle", {31'd0, busy}, 0);
    check("rstchk_idle", {16'd0, resetOsCheckers}, 0);

    // recoveryRcvrLock: two silent re-arms, then failure
    activeLanes = 16'h0003; laneOsDone = 16'h0001; substate = 5'd11;
    expectFinish(1447, 5'd0, 1'b1);
    waitDone(1600);

    // recoverySpeed waits for timeout even with laneOk
    activeLanes = 16'h000F; laneOsDone = 16'h000F; trainToGen = 3'd2; substate = 5'd13;
    expectFinish(13, 5'd11, 1'b0);
    waitDone(50);
    trainToGen = 3'd3;

    // recoveryRcvrCfg with exitToIdle
    exitToIdle = 1'b1; substate = 5'd12;
    expectFinish(3, 5'd18, 1'b0);
    step(1);
    check("dd_12", {31'd0, disableDescrambler}, 1);
    waitDone(50);
    exitToIdle = 1'b0;

    // abort: 4 changed to 5 mid-COUNT
    laneOsDone = '0; substate = 5'd4;
    step(5);
    substate = 5'd5;
    expectFinish(7, 5'd6, 1'b0);
    step(6);
    laneOsDone = 16'h000F;
    waitDone(50);

    // L0, recoveryIdle, phase3
    substate = 5'd10;
    expectFinish(3, 5'd11, 1'b0);
    step(1);
    check("dd_l0", {31'd0, disableDescrambler}, 0);
    waitDone(50);
    substate = 5'd18;
    expectFinish(3, 5'd10, 1'b0);
    step(1);
    check("dd_18", {31'd0, disableDescrambler}, 0);
    waitDone(50);
    substate = 5'd17;
    expectFinish(3, 5'd11, 1'b0);
    waitDone(50);

    // detectQuiet by timeout, detectActive, detectQuiet by rxIdleExit
    laneOsDone = '0; substate = 5'd0;
    expectFinish(123, 5'd1, 1'b0);
    waitDone(200);
    substate = 5'd1;
    expectFinish(3, 5'd2, 1'b0);
    waitDone(50);
    rxIdleExit = 1'b1; substate = 5'd0;
    expectFinish(3, 5'd1, 1'b0);
    waitDone(50);
    rxIdleExit = 1'b0;

    // failures: configurationIdle timeout, empty lane mask
    substate = 5'd9;
    expectFinish(23, 5'd0, 1'b1);
    waitDone(50);
    activeLanes = '0; laneOsDone = 16'h000F; substate = 5'd7;
    expectFinish(243, 5'd0, 1'b1);
    waitDone(300);

    // non-power-of-two mask
    activeLanes = 16'h0005; laneOsDone = 16'h0007; substate = 5'd3;
    expectFinish(3, 5'd4, 1'b0);
    waitDone(50);

    // reset mid-COUNT, then re-arm of the same substate
    laneOsDone = '0; substate = 5'd6;
    step(4);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_exitTo", {27'd0, exitTo}, 0);
    check("mid_rst_rstchk", {16'd0, resetOsCheckers}, 0);
    check("mid_rst_dd", {31'd0, disableDescrambler}, 1);
    check("mid_rst_finish", {31'd0, finish}, 0);
    step(1);
    reset = 1'b1; laneOsDone = 16'h0005;
    expectFinish(3, 5'd7, 1'b0);
    waitDone(50);

    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
